// File: rtl/dev_arb_pkg.sv
// Shared types and constants for the two-master device bus arbiter.
// The optional bus-lock feature is enabled with the DEV_ARB_LOCK_EN macro.
package dev_arb_pkg;

   localparam int RD_LAT_DEFAULT = 2;
   localparam int CNT_W          = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   typedef logic m_idx_t;

   localparam m_idx_t M_CPU = 1'b0;
   localparam m_idx_t M_DMA = 1'b1;

   // One-hot request/ack mask for a master index.
   function automatic logic [1:0] idx_mask(input m_idx_t idx);
      logic [1:0] mask;
      mask = (idx == M_DMA) ? 2'b10 : 2'b01;
      return mask;
   endfunction

endpackage

// File: rtl/dev_arb_rr_pick.sv
// Combinational winner selection for two masters: round-robin on contention,
// optionally restricted to the lock owner while a lock is active.
module dev_arb_rr_pick
   import dev_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  m_idx_t     i_last_gnt,
   input  logic       i_lock_active,
   input  m_idx_t     i_lock_owner,
   output logic       o_gnt_valid,
   output m_idx_t     o_gnt_idx
);

   logic [1:0] w_elig;

   // Masks off every master except the owner while a lock is held.
   always_comb begin
      if (i_lock_active) begin
         w_elig = i_req & idx_mask(i_lock_owner);
      end else begin
         w_elig = i_req;
      end
   end

   // Single requester wins outright; on contention the master not granted last wins.
   always_comb begin
      o_gnt_valid = 1'b0;
      o_gnt_idx   = M_CPU;
      case (w_elig)
         2'b01: begin
            o_gnt_valid = 1'b1;
            o_gnt_idx   = M_CPU;
         end
         2'b10: begin
            o_gnt_valid = 1'b1;
            o_gnt_idx   = M_DMA;
         end
         2'b11: begin
            o_gnt_valid = 1'b1;
            o_gnt_idx   = ~i_last_gnt;
         end
         default: begin
            o_gnt_valid = 1'b0;
            o_gnt_idx   = M_CPU;
         end
      endcase
   end

endmodule

// File: rtl/dev_bus_arbiter.sv
// Two-master (CPU/DMA) arbiter driving one device bus with fixed read latency RD_LAT.
// Optional bus lock via macro DEV_ARB_LOCK_EN; without it m_lock is ignored.
module dev_bus_arbiter
   import dev_arb_pkg::*;
#(
   parameter int RD_LAT = RD_LAT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  m_req,
   input  logic [29:0] m_addr0,
   input  logic [29:0] m_addr1,
   input  logic [31:0] m_wd0,
   input  logic [31:0] m_wd1,
   input  logic [3:0]  m_be0,
   input  logic [3:0]  m_be1,
   input  logic [1:0]  m_we,
   input  logic [1:0]  m_lock,
   output logic [1:0]  m_ack,
   output logic [31:0] m_rdata,
   output logic        busy,
   output logic [29:0] dev_addr,
   output logic [31:0] dev_wd,
   output logic [3:0]  dev_be,
   output logic        dev_we,
   input  logic [31:0] dev_rd
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   m_idx_t           r_gnt;
   m_idx_t           r_last_gnt;

   logic             w_gnt_valid;
   m_idx_t           w_gnt_idx;
   logic             w_lock_active;
   m_idx_t           w_lock_owner;
   logic             w_issue;
   logic             w_capture;
   logic [29:0]      w_sel_addr;
   logic [31:0]      w_sel_wd;
   logic [3:0]       w_sel_be;

   dev_arb_rr_pick u_pick (
      .i_req         (m_req),
      .i_last_gnt    (r_last_gnt),
      .i_lock_active (w_lock_active),
      .i_lock_owner  (w_lock_owner),
      .o_gnt_valid   (w_gnt_valid),
      .o_gnt_idx     (w_gnt_idx)
   );

`ifdef DEV_ARB_LOCK_EN
   logic   r_lock_valid;
   m_idx_t r_lock_owner;

   // Lock follows the winner's m_lock bit at every issue; only the owner can win while held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock_valid <= 1'b0;
         r_lock_owner <= M_CPU;
      end else if (w_issue) begin
         r_lock_valid <= m_lock[w_gnt_idx];
         r_lock_owner <= w_gnt_idx;
      end else begin
         r_lock_valid <= r_lock_valid;
         r_lock_owner <= r_lock_owner;
      end
   end

   assign w_lock_active = r_lock_valid;
   assign w_lock_owner  = r_lock_owner;
`else
   // m_lock is folded into a constant-zero term: connected but inert.
   assign w_lock_active = &{1'b0, m_lock};
   assign w_lock_owner  = M_CPU;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_gnt_valid) begin
               w_state_nxt = WAIT;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         WAIT: begin
            if (r_cnt == {CNT_W{1'b0}}) begin
               w_state_nxt = RESP;
            end else begin
               w_state_nxt = WAIT;
            end
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output decode: issue/capture strobes and the winner's request fields.
   always_comb begin
      w_issue   = (r_state == IDLE) && w_gnt_valid;
      w_capture = (r_state == WAIT) && (r_cnt == {CNT_W{1'b0}});
      if (w_gnt_idx == M_DMA) begin
         w_sel_addr = m_addr1;
         w_sel_wd   = m_wd1;
         w_sel_be   = m_be1;
      end else begin
         w_sel_addr = m_addr0;
         w_sel_wd   = m_wd0;
         w_sel_be   = m_be0;
      end
   end

   // Registered datapath and master-facing outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= {CNT_W{1'b0}};
         r_gnt      <= M_CPU;
         r_last_gnt <= M_DMA;
         m_ack      <= 2'b00;
         m_rdata    <= 32'h0000_0000;
         busy       <= 1'b0;
         dev_addr   <= 30'h0000_0000;
         dev_wd     <= 32'h0000_0000;
         dev_be     <= 4'h0;
         dev_we     <= 1'b0;
      end else begin
         if (w_issue) begin
            r_gnt      <= w_gnt_idx;
            r_last_gnt <= w_gnt_idx;
            r_cnt      <= CNT_LOAD;
            dev_addr   <= w_sel_addr;
            dev_wd     <= w_sel_wd;
            dev_be     <= w_sel_be;
            dev_we     <= m_we[w_gnt_idx];
            busy       <= 1'b1;
         end else begin
            dev_we <= 1'b0;
            if ((r_state == WAIT) && (r_cnt != {CNT_W{1'b0}})) begin
               r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               r_cnt <= r_cnt;
            end
            if (r_state == RESP) begin
               busy <= 1'b0;
            end else begin
               busy <= busy;
            end
         end

         // Write transactions also capture dev_rd; the value is simply unused then.
         if (w_capture) begin
            m_rdata <= dev_rd;
            m_ack   <= idx_mask(r_gnt);
         end else if (r_state == RESP) begin
            m_ack <= 2'b00;
         end else begin
            m_ack <= m_ack;
         end
      end
   end

endmodule

// File: doc/dev_bus_arbiter.md
DEV_BUS_ARBITER -- requirements
Module: dev_bus_arbiter

Interface
REQ-001 Parameter: RD_LAT, default 2, edges from issue to read-data capture, legal range 2..15.
REQ-002 Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
REQ-003 Ports:
- m_req  in  2  per-master request, index 0 = CPU, 1 = DMA.
- m_addr0/m_addr1  in  30  word address [31:2].
- m_wd0/m_wd1  in  32  write data.
- m_be0/m_be1  in  4  byte enables.
- m_we  in  2  write strobe per master.
- m_lock  in  2  lock request per master.
REQ-004 Ports:
- m_ack  out  2  one-cycle completion pulse per master.
- m_rdata  out  32  captured read data.
- busy  out  1  transaction in flight.
REQ-005 Ports:
- dev_addr  out  30  bus address [31:2].
- dev_wd  out  32  bus write data.
- dev_be  out  4  bus byte enables.
- dev_we  out  1  bus write strobe.
- dev_rd  in  32  bus read data, combinational from the bus's registered address.

Function
REQ-006 The FSM SHALL have states IDLE, WAIT and RESP; all outputs SHALL be registered.
REQ-007 IDLE with any m_req high at edge E0 SHALL select a winner, latch its addr/wd/be into dev_*, set dev_we=m_we[winner], load cnt=RD_LAT-1 and go to WAIT.
REQ-008 dev_we SHALL be high only in the single cycle after E0; dev_addr/wd/be SHALL hold until the next issue.
REQ-009 WAIT SHALL decrement cnt each edge; at the edge where cnt==0 it SHALL capture dev_rd into m_rdata, set m_ack[winner]=1 and enter RESP.
REQ-010 RESP SHALL last one cycle, perform no arbitration, clear m_ack at exit and return to IDLE.
REQ-011 m_ack SHALL be high exactly during the cycle after edge E0+RD_LAT; writes SHALL also be acked, and m_rdata is then don't-care.
REQ-012 Masters SHALL hold req/addr/wd/be/we stable until ack and drop req at the edge ending the ack cycle.
REQ-013 A single requester SHALL win; with both requesting, the master not equal to last_gnt SHALL win (round-robin), and last_gnt SHALL update on each issue.
REQ-014 busy SHALL be high in WAIT and RESP and low in IDLE.
REQ-015 A request arriving during WAIT/RESP SHALL be held off; back-to-back throughput SHALL be one transaction per RD_LAT+2 cycles.

Reset
REQ-016 rst_n low SHALL immediately force IDLE, cnt=0, last_gnt=1 (so the CPU wins first), lock cleared, and m_ack, m_rdata, busy, dev_addr, dev_wd, dev_be and dev_we all zero.
REQ-017 Reset mid-transaction SHALL abort it with no ack; after release, arbitration SHALL restart at the first edge with rst_n high.

Configuration
REQ-018 Macro DEV_ARB_LOCK_EN: when defined, issuing for master i with m_lock[i]=1 SHALL set lock_owner=i, and while locked only master i SHALL be granted; lock_owner SHALL clear when master i issues with m_lock[i]=0.
REQ-019 Without DEV_ARB_LOCK_EN, the m_lock ports SHALL exist but be ignored, and arbitration SHALL be pure round-robin.

Structure
REQ-020 Package dev_arb_pkg SHALL hold the state enum (IDLE/WAIT/RESP), the master-index typedef, and the RD_LAT default constant.
REQ-021 Sub-module dev_arb_rr_pick SHALL implement the combinational 2-way round-robin/lock winner selection; the rest SHALL be flat.

Verification
REQ-022 Reset, then m_req=01, read addr 0x20, dev_rd=0xDEADBEEF -> m_ack[0] pulses one cycle after edge E0+2, m_rdata=0xDEADBEEF, dev_we never high.
REQ-023 m_req=10, write, wd=0x12345678, be=0xF -> dev_we high exactly 1 cycle after E0, dev_wd=0x12345678, m_ack[1] pulses.
REQ-024 m_req=11 held for 4 transactions -> grant order M0, M1, M0, M1, with acks 4 cycles apart.
REQ-025 rst_n low during WAIT -> no m_ack, all outputs 0; after release, m_req=10 is granted normally.
REQ-026 DEV_ARB_LOCK_EN, M1 issues with lock=1 while M0 also requests -> M1 granted twice; after M1 issues with lock=0, M0 is granted next.
